random_key_scheduler: RTL and testbench
=======================================

RANDOM_KEY_SCHEDULER -- requirements
Module: random_key_scheduler

Interface
REQ-001 Parameter KEY_BYTES, default 4, SHALL set the number of random bytes per key (legal range 1..16).
REQ-002 Parameter STRIDE, default 8, SHALL set the number of generator enable cycles between samples (legal range 1..255).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 req  input  2  SHALL carry per-requester key requests, level-held, bit i = requester i.
REQ-006 gen_stream  input  8  SHALL carry the current byte from the LFSR random byte generator.
REQ-007 gen_ena  output  1  SHALL drive the generator enable; a high cycle advances the generator one step.
REQ-008 key_data  output  8*KEY_BYTES  SHALL carry the assembled key.
REQ-009 key_valid  output  1  SHALL flag a completed key; single-cycle pulse.
REQ-010 key_owner  output  1  SHALL give the index of the requester served by the current or last key.
REQ-011 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, STEP, SAMPLE and DONE.
REQ-013 IDLE: req==0 -> stay; otherwise grant one requester, latch key_owner, clear the step and byte counters, and go to STEP.
REQ-014 Arbitration SHALL be round-robin: with both bits set, grant the requester other than the last-served one; with a single bit set, grant that requester.
REQ-015 STEP: gen_ena=1 every cycle; after exactly STRIDE STEP cycles, go to SAMPLE.
REQ-016 SAMPLE: gen_ena=0; key_data <= {key_data[8*KEY_BYTES-9:0], gen_stream}, so the first byte ends most significant; byte counter +1.
REQ-017 SAMPLE exit: if byte counter reaches KEY_BYTES -> DONE; else clear step counter -> STEP.
REQ-018 DONE: key_valid=1 for exactly one cycle; record key_owner as last-served; go to IDLE.
REQ-019 gen_ena SHALL be 0 in IDLE, SAMPLE and DONE, so gen_stream is stable when captured.
REQ-020 Latency: key_valid SHALL assert exactly 1+KEY_BYTES*(STRIDE+1) cycles after the first IDLE cycle with req!=0 (37 at defaults).
REQ-021 key_data SHALL stay stable from DONE until the first SAMPLE of the next key; it is defined only while key_valid=1.
REQ-022 Deassertion of req after grant SHALL NOT abort the key; the key completes and key_valid still pulses.
REQ-023 A requester SHALL drop req in the cycle after key_valid; a req still high in that IDLE cycle is a new request and goes through arbitration (REQ-014).
REQ-024 Requests arriving in a non-IDLE state SHALL be held pending by the requester, not queued internally.
REQ-025 Counters SHALL be sized for the parameter maxima, with no wrap before the terminal count.

Reset
REQ-026 rst=0 at a clock edge SHALL force IDLE, gen_ena=0, key_valid=0, busy=0, key_data=0, key_owner=0, and last-served=1, so requester 0 wins the first tie.
REQ-027 Reset asserted mid-key SHALL discard the partial key, with no key_valid pulse; the generator's own state is not reset by this block.
REQ-028 Outputs SHALL hold their reset values for every cycle rst=0 is sampled, regardless of req.

Verification
REQ-029 Single request: req=01 after reset, defaults -> key_valid pulse 37 cycles later, key_owner=0, gen_ena high for exactly 32 cycles, key_data equal to four model-generated bytes sampled at steps 8/16/24/32, first byte in [31:24].
REQ-030 Tie: req=11 held -> first key key_owner=0, next key key_owner=1, alternating; busy low exactly one IDLE cycle between keys.
REQ-031 Withdrawal: req=10 for 1 cycle then 00 -> key still completes, key_valid at cycle 37, key_owner=1, then idle with busy=0.
REQ-032 Mid-key reset: rst=0 for one edge during the 3rd byte's STEP -> next cycle busy=0, gen_ena=0, key_data=0, no key_valid pulse.
REQ-033 Parameter sweep: KEY_BYTES=1, STRIDE=1 -> key_valid 3 cycles after request, one gen_ena cycle, key_data=gen_stream after one step.
REQ-034 Protocol check: assert gen_ena never high in SAMPLE or DONE, and key_valid never high on two consecutive cycles.

Source files
------------

// File: rtl/random_key_scheduler_if.sv
// Request/generator/key bundle between the key scheduler and its clients.
// Latency: none, wiring only.
// Backpressure: none; requesters hold req high until they see key_valid.
interface random_key_scheduler_if #(
  parameter int KEY_BYTES = 4
);
  logic [1:0]             req;
  logic [7:0]             gen_stream;
  logic                   gen_ena;
  logic [8*KEY_BYTES-1:0] key_data;
  logic                   key_valid;
  logic                   key_owner;
  logic                   busy;

  // Scheduler side: consumes requests and generator bytes, produces keys.
  modport master (
    input  req,
    input  gen_stream,
    output gen_ena,
    output key_data,
    output key_valid,
    output key_owner,
    output busy
  );

  // Client side: requesters plus the random byte generator.
  modport slave (
    output req,
    output gen_stream,
    input  gen_ena,
    input  key_data,
    input  key_valid,
    input  key_owner,
    input  busy
  );
endinterface

// File: rtl/random_key_scheduler.sv
// Builds KEY_BYTES-byte keys from an LFSR byte stream, sampling every STRIDE generator steps.
// Latency: key_valid pulses 1+KEY_BYTES*(STRIDE+1) cycles after the first IDLE cycle with req!=0.
// Backpressure: none; requests seen outside IDLE are left pending on the requester side.
module random_key_scheduler #(
  parameter int KEY_BYTES = 4,
  parameter int STRIDE    = 8
) (
  input logic                    clk,
  input logic                    rst,
  random_key_scheduler_if.master bus
);

  localparam int KW = 8 * KEY_BYTES;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STEP   = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Terminal counts; the counters are wide enough for STRIDE=255 and KEY_BYTES=16.
  localparam logic [7:0] STEP_LAST = 8'(STRIDE - 1);
  localparam logic [4:0] BYTE_LAST = 5'(KEY_BYTES - 1);

  logic [1:0]    state;
  logic [7:0]    step_cnt;
  logic [4:0]    byte_cnt;
  logic [KW-1:0] key_q;
  logic          owner_q;
  logic          last_q;
  logic          grant;
  logic [KW+7:0] shifted;

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    grant = 1'b0;
    if (bus.req == 2'b11) begin
      grant = ~last_q;
    end else begin
      grant = bus.req[1];
    end
  end

  // New byte enters at the bottom so the first sampled byte ends up most significant.
  assign shifted = {key_q, bus.gen_stream};

  // Main FSM: grant, step the generator STRIDE times, sample a byte, repeat, then flag the key.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      step_cnt <= '0;
      byte_cnt <= '0;
      key_q    <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req != 2'b00) begin
            owner_q  <= grant;
            step_cnt <= '0;
            byte_cnt <= '0;
            state    <= STEP;
          end
        end
        STEP: begin
          if (step_cnt == STEP_LAST) begin
            state <= SAMPLE;
          end else begin
            step_cnt <= step_cnt + 8'd1;
          end
        end
        SAMPLE: begin
          key_q    <= shifted[KW-1:0];
          byte_cnt <= byte_cnt + 5'd1;
          if (byte_cnt == BYTE_LAST) begin
            state <= DONE;
          end else begin
            step_cnt <= '0;
            state    <= STEP;
          end
        end
        DONE: begin
          last_q <= owner_q;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state, so gen_stream is frozen in SAMPLE and DONE.
  assign bus.gen_ena   = (state == STEP);
  assign bus.key_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.key_data  = key_q;
  assign bus.key_owner = owner_q;

endmodule

// File: tb/tb_random_key_scheduler.sv
// Bench for random_key_scheduler: default instance plus a KEY_BYTES=1/STRIDE=1 instance.
// Each instance is fed by its own 8-bit LFSR that advances only while gen_ena is high.
// Expected keys, owners and latencies come from the arbitration/sampling rules directly.
module tb_random_key_scheduler;

  localparam int KB0  = 4;
  localparam int ST0  = 8;
  localparam int LAT0 = 1 + KB0 * (ST0 + 1);
  localparam int KB1  = 1;
  localparam int ST1  = 1;
  localparam int LAT1 = 1 + KB1 * (ST1 + 1);

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [7:0] lfsr0;
  logic [7:0] lfsr1;
  logic       last_m0;
  logic       last_m1;
  logic       prev_kv0, prev_ge0, prev_kv1, prev_ge1;

  random_key_scheduler_if #(.KEY_BYTES(KB0)) bus0 ();
  random_key_scheduler_if #(.KEY_BYTES(KB1)) bus1 ();

  random_key_scheduler #(.KEY_BYTES(KB0), .STRIDE(ST0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.master)
  );

  random_key_scheduler #(.KEY_BYTES(KB1), .STRIDE(ST1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [7:0] adv(input logic [7:0] s, input int n);
    logic [7:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = lfsr_next(v);
    return v;
  endfunction

  // Generator models: free-running state, never reset by the scheduler.
  initial begin
    lfsr0 = 8'($urandom_range(1, 255));
    lfsr1 = 8'($urandom_range(1, 255));
  end
  always @(posedge clk) begin
    if (bus0.gen_ena) lfsr0 <= lfsr_next(lfsr0);
    if (bus1.gen_ena) lfsr1 <= lfsr_next(lfsr1);
  end
  assign bus0.gen_stream = lfsr0;
  assign bus1.gen_stream = lfsr1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Whenever a key is flagged: no pulse the cycle before, and the generator idle now and one cycle earlier.
  initial begin
    prev_kv0 = 1'b0; prev_ge0 = 1'b0; prev_kv1 = 1'b0; prev_ge1 = 1'b0;
  end
  always @(negedge clk) begin
    if (bus0.key_valid) check("protocol0", {61'd0, prev_kv0, prev_ge0, bus0.gen_ena}, 64'd0);
    if (bus1.key_valid) check("protocol1", {61'd0, prev_kv1, prev_ge1, bus1.gen_ena}, 64'd0);
    prev_kv0 = bus0.key_valid;
    prev_ge0 = bus0.gen_ena;
    prev_kv1 = bus1.key_valid;
    prev_ge1 = bus1.gen_ena;
  end

  task automatic check_reset0(input string tag);
    check({tag, "_busy"},  64'(bus0.busy), 64'd0);
    check({tag, "_gen"},   64'(bus0.gen_ena), 64'd0);
    check({tag, "_valid"}, 64'(bus0.key_valid), 64'd0);
    check({tag, "_data"},  64'(bus0.key_data), 64'd0);
    check({tag, "_owner"}, 64'(bus0.key_owner), 64'd0);
  endtask

  // One key on the default instance; called in an IDLE cycle, which becomes cycle 0.
  task automatic do_key0(input logic [1:0] r, input bit withdraw, input bit keep_req, input string tag);
    logic [7:0]  s0;
    logic [31:0] exp_key;
    logic        exp_owner;
    int          n;
    int          gen_cnt;
    bit          seen;
    s0        = lfsr0;
    exp_owner = (r == 2'b11) ? ~last_m0 : r[1];
    exp_key   = '0;
    for (int k = 1; k <= KB0; k++) exp_key = {exp_key[23:0], adv(s0, ST0 * k)};
    bus0.req = r;
    n = 0; gen_cnt = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      tick();
      n++;
      if (withdraw && n == 1) bus0.req = 2'b00;
      if (bus0.gen_ena) gen_cnt++;
      if (bus0.key_valid) seen = 1'b1;
    end
    check({tag, "_latency"}, 64'(n), 64'(LAT0));
    check({tag, "_owner"},   64'(bus0.key_owner), 64'(exp_owner));
    check({tag, "_key"},     64'(bus0.key_data), 64'(exp_key));
    check({tag, "_gen_cnt"}, 64'(gen_cnt), 64'(KB0 * ST0));
    check({tag, "_busy_done"}, 64'(bus0.busy), 64'd1);
    last_m0 = exp_owner;
    if (!keep_req) bus0.req = 2'b00;
    tick();
    check({tag, "_idle_busy"},  64'(bus0.busy), 64'd0);
    check({tag, "_idle_valid"}, 64'(bus0.key_valid), 64'd0);
    check({tag, "_key_hold"},   64'(bus0.key_data), 64'(exp_key));
  endtask

  // One key on the KEY_BYTES=1, STRIDE=1 instance.
  task automatic do_key1(input logic [1:0] r, input string tag);
    logic [7:0] s0;
    logic       exp_owner;
    int         n;
    int         gen_cnt;
    bit         seen;
    s0        = lfsr1;
    exp_owner = (r == 2'b11) ? ~last_m1 : r[1];
    bus1.req  = r;
    n = 0; gen_cnt = 0; seen = 1'b0;
    while (!seen && n < 50) begin
      tick();
      n++;
      if (bus1.gen_ena) gen_cnt++;
      if (bus1.key_valid) seen = 1'b1;
    end
    check({tag, "_latency"}, 64'(n), 64'(LAT1));
    check({tag, "_owner"},   64'(bus1.key_owner), 64'(exp_owner));
    check({tag, "_key"},     64'(bus1.key_data), 64'(adv(s0, ST1)));
    check({tag, "_gen_cnt"}, 64'(gen_cnt), 64'(KB1 * ST1));
    last_m1  = exp_owner;
    bus1.req = 2'b00;
    tick();
    check({tag, "_idle_busy"}, 64'(bus1.busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int         pulses;
    logic [1:0] r;
    checks   = 0;
    failures = 0;
    last_m0  = 1'b1;
    last_m1  = 1'b1;

    // Reset held with requests present: outputs stay at reset values.
    rst      = 1'b0;
    bus0.req = 2'b11;
    bus1.req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset0("reset");
    end
    check("reset1_busy", 64'(bus1.busy), 64'd0);
    rst      = 1'b1;
    bus0.req = 2'b00;
    bus1.req = 2'b00;
    tick();

    // Tie held across keys: owners alternate starting at requester 0.
    do_key0(2'b11, 1'b0, 1'b1, "tie_a");
    do_key0(2'b11, 1'b0, 1'b1, "tie_b");
    do_key0(2'b11, 1'b0, 1'b0, "tie_c");

    // Single request and withdrawn request.
    do_key0(2'b01, 1'b0, 1'b0, "single");
    do_key0(2'b10, 1'b1, 1'b0, "withdraw");

    // Randomised request patterns, gaps and withdrawals.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      r = 2'($urandom_range(1, 3));
      do_key0(r, 1'($urandom_range(0, 1)), 1'b0, "rand");
    end

    // Reset during the third byte's STEP phase discards the key.
    bus0.req = 2'b01;
    repeat (20) tick();
    check("mid_pre", 64'({bus0.busy, bus0.gen_ena}), 64'd3);
    rst = 1'b0;
    tick();
    check_reset0("mid_rst");
    rst      = 1'b1;
    bus0.req = 2'b00;
    last_m0  = 1'b1;
    last_m1  = 1'b1;
    pulses   = 0;
    repeat (45) begin
      tick();
      if (bus0.key_valid) pulses++;
    end
    check("mid_no_valid", 64'(pulses), 64'd0);
    check("mid_idle_busy", 64'(bus0.busy), 64'd0);
    do_key0(2'b11, 1'b0, 1'b0, "post_rst_tie");

    // Minimum-parameter instance.
    do_key1(2'b01, "sweep_a");
    do_key1(2'b10, "sweep_b");
    do_key1(2'b11, "sweep_c");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
